// File: rtl/bias_sched_pkg.sv
// rtl/bias_sched_pkg.sv - shared types and defaults for the bias bank scheduler
package bias_sched_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;

    localparam logic BANK0 = 1'b0;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_LOAD = 2'd1,
        F_FULL = 2'd2
    } fill_state_t;

endpackage

// File: rtl/bias_fill_fsm.sv
// rtl/bias_fill_fsm.sv - idle-bank fill FSM with length latch, write pointer and registered RAM write port
module bias_fill_fsm
    import bias_sched_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              act_bank,
    input  logic              swap_accept,
    output logic              load_done,
    output logic              layer_ready,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_waddr,
    output logic [DATA_W-1:0] mem_wdata
);

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    fill_state_t       state;
    logic [ADDR_W:0]   len;
    logic [ADDR_W-1:0] wr_ptr;
    logic              len_ok;
    logic              beat;
    logic              last_beat;

    // Readiness flags come straight off the state register so a beat arriving
    // on the cycle the fill completes is never accepted.
    assign ld_ready    = (state == F_LOAD);
    assign layer_ready = (state == F_FULL);

    assign len_ok    = (load_len != '0) && (load_len <= MAX_LEN);
    assign beat      = ld_valid && ld_ready;
    assign last_beat = ({1'b0, wr_ptr} == (len - 1'b1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= F_IDLE;
            len       <= '0;
            wr_ptr    <= '0;
            load_done <= 1'b0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else begin
            load_done <= 1'b0;
            mem_we    <= beat;
            if (beat) begin
                mem_waddr <= {~act_bank, wr_ptr};
                mem_wdata <= ld_data;
                wr_ptr    <= wr_ptr + 1'b1;
            end
            case (state)
                F_IDLE: begin
                    if (load_start && len_ok) begin
                        len    <= load_len;
                        wr_ptr <= '0;
                        state  <= F_LOAD;
                    end
                end
                F_LOAD: begin
                    if (beat && last_beat) begin
                        state     <= F_FULL;
                        load_done <= 1'b1;
                    end
                end
                F_FULL: begin
                    if (swap_accept) begin
                        state <= F_IDLE;
                    end
                end
                default: state <= F_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/bias_bank_sched.sv
// rtl/bias_bank_sched.sv - ping-pong bias bank scheduler; optional BIAS_SCHED_STALL_CNT_EN adds stall_cnt
module bias_bank_sched
    import bias_sched_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    output logic              load_done,
    output logic              layer_ready,
    input  logic              layer_start,
    input  logic              layer_end,
    output logic              layer_active,
    output logic              swap_err,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              mem_re,
    output logic [ADDR_W:0]   mem_raddr,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_waddr,
    output logic [DATA_W-1:0] mem_wdata
`ifdef BIAS_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    logic act_bank;
    logic swap_accept;
    logic swap_reject;

    // A swap needs a full idle bank and a free (or just-released) active bank.
    assign swap_accept = layer_start && layer_ready && (!layer_active || layer_end);
    assign swap_reject = layer_start && !swap_accept;

    assign mem_re    = rd_en && layer_active;
    assign mem_raddr = {act_bank, rd_addr};

    bias_fill_fsm #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fill (
        .clk         (clk),
        .rstn        (rstn),
        .load_start  (load_start),
        .load_len    (load_len),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .act_bank    (act_bank),
        .swap_accept (swap_accept),
        .load_done   (load_done),
        .layer_ready (layer_ready),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act_bank     <= BANK0;
            layer_active <= 1'b0;
            swap_err     <= 1'b0;
        end else begin
            swap_err <= swap_reject;
            if (swap_accept) begin
                act_bank     <= ~act_bank;
                layer_active <= 1'b1;
            end else if (layer_end) begin
                layer_active <= 1'b0;
            end
        end
    end

`ifdef BIAS_SCHED_STALL_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if (swap_reject && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bias_bank_sched.sv
// tb/tb_bias_bank_sched.sv - scoreboard bench for bias_bank_sched
module tb_bias_bank_sched;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rstn;
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic              ld_valid;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data;
    logic              load_done;
    logic              layer_ready;
    logic              layer_start;
    logic              layer_end;
    logic              layer_active;
    logic              swap_err;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              mem_re;
    logic [ADDR_W:0]   mem_raddr;
    logic              mem_we;
    logic [ADDR_W:0]   mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
`ifdef BIAS_SCHED_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    logic [ADDR_W+DATA_W:0] exp_q[$];
    logic fill_bank;

    bias_bank_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .load_start   (load_start),
        .load_len     (load_len),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_data      (ld_data),
        .load_done    (load_done),
        .layer_ready  (layer_ready),
        .layer_start  (layer_start),
        .layer_end    (layer_end),
        .layer_active (layer_active),
        .swap_err     (swap_err),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .mem_re       (mem_re),
        .mem_raddr    (mem_raddr),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata)
`ifdef BIAS_SCHED_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every RAM write must match the oldest expected beat.
    always @(negedge clk) begin
        if (mem_we) begin
            logic [ADDR_W+DATA_W:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL mem_write_unexpected: got waddr=%h wdata=%h, required no write", mem_waddr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({mem_waddr, mem_wdata} !== e) begin
                    failures++;
                    $display("FAIL mem_write: got waddr=%h wdata=%h, required waddr=%h wdata=%h",
                             mem_waddr, mem_wdata, e[ADDR_W+DATA_W:DATA_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    task automatic start_load(input logic [ADDR_W:0] len);
        @(negedge clk);
        load_start = 1'b1;
        load_len   = len;
        @(negedge clk);
        load_start = 1'b0;
        load_len   = '0;
    endtask

    task automatic send_beats(input int n, input bit gaps);
        int i = 0;
        int cyc = 0;
        logic [ADDR_W-1:0] ptr;
        while (i < n && cyc < n * 8 + 20) begin
            @(negedge clk);
            cyc++;
            ld_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            ld_data  = $urandom();
            if (ld_valid && ld_ready) begin
                ptr = i[ADDR_W-1:0];
                exp_q.push_back({fill_bank, ptr, ld_data});
                i++;
            end
        end
        @(negedge clk);
        ld_valid = 1'b0;
        checks++;
        if (i != n) begin
            failures++;
            $display("FAIL beat_budget: accepted %0d beats, required %0d", i, n);
        end
    endtask

    task automatic check_full(input string name);
        checks++;
        if ({load_done, layer_ready, ld_ready} !== 3'b110) begin
            failures++;
            $display("FAIL %s_done: got load_done/layer_ready/ld_ready=%b, required 110", name,
                     {load_done, layer_ready, ld_ready});
        end
        @(negedge clk);
        checks++;
        if ({load_done, layer_ready} !== 2'b01) begin
            failures++;
            $display("FAIL %s_done_pulse: got load_done/layer_ready=%b, required 01", name, {load_done, layer_ready});
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0; load_start = 0; load_len = '0; ld_valid = 0; ld_data = '0;
        layer_start = 0; layer_end = 0; rd_en = 0; rd_addr = '0;
        fill_bank = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ld_ready, load_done, layer_ready, layer_active, swap_err, mem_we, mem_waddr, mem_wdata, mem_re} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got nonzero outputs waddr=%h wdata=%h flags=%b, required all 0",
                     mem_waddr, mem_wdata, {ld_ready, load_done, layer_ready, layer_active, swap_err, mem_we});
        end
        checks++;
        if (mem_raddr !== 10'h000) begin
            failures++;
            $display("FAIL reset_bank: got mem_raddr=%h, required 000", mem_raddr);
        end
        rstn = 1'b1;
    endtask

    task automatic test_bad_len;
        start_load(10'd0);
        checks++;
        if (ld_ready !== 1'b0) begin
            failures++;
            $display("FAIL len_zero: got ld_ready=%b, required 0", ld_ready);
        end
        start_load(10'd513);
        checks++;
        if (ld_ready !== 1'b0) begin
            failures++;
            $display("FAIL len_over: got ld_ready=%b, required 0", ld_ready);
        end
    endtask

    task automatic test_load4;
        start_load(10'd4);
        checks++;
        if (ld_ready !== 1'b1) begin
            failures++;
            $display("FAIL load4_ready: got ld_ready=%b, required 1", ld_ready);
        end
        send_beats(4, 1'b0);
        check_full("load4");
    endtask

    task automatic test_swap;
        @(negedge clk);
        layer_start = 1'b1;
        @(negedge clk);
        layer_start = 1'b0;
        rd_en = 1'b1; rd_addr = 9'd5;
        #1;
        checks++;
        if ({layer_active, layer_ready, swap_err, mem_re, mem_raddr} !== {4'b1001, 10'h205}) begin
            failures++;
            $display("FAIL swap1: got active/ready/err/re=%b raddr=%h, required 1001 raddr=205",
                     {layer_active, layer_ready, swap_err, mem_re}, mem_raddr);
        end
        fill_bank = 1'b0;
    endtask

    task automatic test_reject_and_fill512;
        start_load(10'd512);
        layer_start = 1'b1;
        @(negedge clk);
        layer_start = 1'b0;
        checks++;
        if ({swap_err, mem_raddr} !== {1'b1, 10'h205}) begin
            failures++;
            $display("FAIL reject_load: got swap_err=%b raddr=%h, required 1 205", swap_err, mem_raddr);
        end
`ifdef BIAS_SCHED_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'd1) begin
            failures++;
            $display("FAIL stall_cnt1: got %0d, required 1", stall_cnt);
        end
`endif
        send_beats(512, 1'b1);
        check_full("load512");
        // Full idle bank but layer still busy: swap must be refused.
        layer_start = 1'b1;
        @(negedge clk);
        layer_start = 1'b0;
        checks++;
        if ({swap_err, layer_ready, mem_raddr} !== {2'b11, 10'h205}) begin
            failures++;
            $display("FAIL reject_busy: got swap_err/ready=%b raddr=%h, required 11 205", {swap_err, layer_ready}, mem_raddr);
        end
`ifdef BIAS_SCHED_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'd2) begin
            failures++;
            $display("FAIL stall_cnt2: got %0d, required 2", stall_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back_end_start;
        @(negedge clk);
        layer_start = 1'b1; layer_end = 1'b1;
        load_start = 1'b1; load_len = 10'd4;
        @(negedge clk);
        layer_start = 1'b0; layer_end = 1'b0;
        load_start = 1'b0; load_len = '0;
        #1;
        checks++;
        if ({layer_active, layer_ready, swap_err, ld_ready, mem_raddr} !== {4'b1000, 10'h005}) begin
            failures++;
            $display("FAIL end_start: got active/ready/err/ld_ready=%b raddr=%h, required 1000 005",
                     {layer_active, layer_ready, swap_err, ld_ready}, mem_raddr);
        end
        @(negedge clk);
        checks++;
        if (ld_ready !== 1'b0) begin
            failures++;
            $display("FAIL end_start_load_ignored: got ld_ready=%b, required 0", ld_ready);
        end
        layer_end = 1'b1;
        @(negedge clk);
        layer_end = 1'b0;
        #1;
        checks++;
        if ({layer_active, mem_re} !== 2'b00) begin
            failures++;
            $display("FAIL layer_end: got active/re=%b, required 00", {layer_active, mem_re});
        end
        fill_bank = 1'b1;
    endtask

    task automatic test_reset_midload;
        start_load(10'd8);
        send_beats(2, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        rd_en = 1'b0; rd_addr = '0;
        #1;
        checks++;
        if ({ld_ready, load_done, layer_ready, layer_active, swap_err, mem_we, mem_waddr, mem_wdata, mem_raddr} !== '0) begin
            failures++;
            $display("FAIL reset_mid: got flags=%b waddr=%h wdata=%h raddr=%h, required all 0",
                     {ld_ready, load_done, layer_ready, layer_active, swap_err, mem_we}, mem_waddr, mem_wdata, mem_raddr);
        end
        @(negedge clk);
        rstn = 1'b1;
        fill_bank = 1'b1;
        start_load(10'd8);
        send_beats(8, 1'b1);
        check_full("reload8");
    endtask

    initial begin
        test_reset();
        test_bad_len();
        test_load4();
        test_swap();
        test_reject_and_fill512();
        test_back_to_back_end_start();
        test_reset_midload();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending writes, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bias_bank_sched.md
# bias_bank_sched

Ping-pong bank scheduler for the bias memory. It splits a 2×2^ADDR_W-word bias RAM into two banks. The DMA stream fills the idle bank with the next layer's biases while the compute engine reads the active bank, and the banks swap at layer boundaries. It sits between the DMA loader, the layer FSM and the bias RAM, and owns every RAM address and write enable.

## Interface
- ADDR_W, 9, per-bank word-address width
- DATA_W, 32, bias word width
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- load_start  in  1  request to fill the idle bank
- load_len  in  ADDR_W+1  word count for the fill, 1..2^ADDR_W; sampled with load_start
- ld_valid  in  1  DMA beat valid
- ld_ready  out  1  beat accepted when ld_valid&&ld_ready
- ld_data  in  DATA_W  bias word
- load_done  out  1  one-cycle pulse, fill complete
- layer_ready  out  1  idle bank full, swap possible
- layer_start  in  1  layer FSM requests swap and start
- layer_end  in  1  active layer finished with its biases
- layer_active  out  1  active bank in use
- swap_err  out  1  one-cycle pulse, layer_start rejected
- rd_en  in  1  compute read strobe
- rd_addr  in  ADDR_W  compute read address within active bank
- mem_re  out  1  RAM read enable (= rd_en && layer_active)
- mem_raddr  out  ADDR_W+1  {act_bank, rd_addr}, combinational
- mem_we  out  1  RAM write enable, registered
- mem_waddr  out  ADDR_W+1  {~act_bank, wr_ptr}, registered
- mem_wdata  out  DATA_W  registered ld_data

## Operation
- Fill FSM states:
  - F_IDLE: idle bank empty.
  - F_LOAD: ld_ready=1.
  - F_FULL: layer_ready=1.
- F_IDLE + load_start with load_len in 1..2^ADDR_W → F_LOAD. This latches len and clears wr_ptr. load_len=0 or out of range: request ignored, no error.
- load_start in F_LOAD or F_FULL is ignored.
- In F_LOAD, each accepted beat writes at wr_ptr, then wr_ptr++. Accepting beat number len → F_FULL, with a load_done pulse.
- layer_start is accepted iff F_FULL && (!layer_active || layer_end). On accept:
  - act_bank toggles.
  - layer_active is set.
  - Fill FSM → F_IDLE.
- On reject: swap_err pulses and no state changes.
- layer_end alone clears layer_active. layer_end together with an accepted layer_start leaves layer_active at 1.
- The active bank is never written. Reads with layer_active=0 produce mem_re=0.
- load_start in the same cycle as an accepted layer_start is ignored, because the fill state is still F_FULL in that cycle.

## Timing
- Reset values:
  - Fill FSM = F_IDLE; act_bank = 0.
  - All outputs 0: ld_ready, load_done, layer_ready, layer_active, swap_err, mem_we, mem_waddr, mem_wdata.
- load_start at cycle T → ld_ready=1 from T+1.
- Beat accepted at cycle N → mem_we/mem_waddr/mem_wdata valid at N+1.
- Last beat at N → at N+1: load_done=1, layer_ready=1, ld_ready=0. ld_ready drops combinationally off state, so no extra beat is accepted.
- layer_start accepted at T → at T+1: act_bank flipped, layer_ready=0, layer_active=1. load_start is accepted from T+1.
- mem_raddr/mem_re are combinational. RAM data latency is owned by the RAM, not this block.
- An asynchronous reset mid-load abandons the fill. The partial bank contents are treated as invalid.

## Configuration
- BIAS_SCHED_STALL_CNT_EN:
  - Defined: adds output stall_cnt [15:0]. It counts cycles where layer_start=1 and the swap is rejected. It saturates at 16'hFFFF and is cleared only by rstn.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package bias_sched_pkg holds:
  - the fill state enum (F_IDLE/F_LOAD/F_FULL, 2 bits);
  - the ADDR_W/DATA_W defaults;
  - a bank-select helper constant (BANK0 = 1'b0).
- Sub-module bias_fill_fsm contains the fill FSM, len latch, wr_ptr and registered write port.
- The top level contains act_bank, layer_active, swap arbitration and read mapping.

## Test plan
- Reset, then load_len=4 with 4 back-to-back beats D0..D3 → mem_waddr 0x200..0x203 with D0..D3, load_done on the cycle after D3, layer_ready=1.
- layer_start while F_FULL and idle → act_bank=1, layer_active=1; rd_en with rd_addr=5 → mem_raddr=0x205, mem_re=1.
- layer_start while F_LOAD → swap_err pulse, act_bank unchanged. With BIAS_SCHED_STALL_CNT_EN defined, stall_cnt=1.
- Second layer fill while layer 1 active: load_len=512 → waddr 0x000..0x1FF; the active bank is never written.
- layer_end and layer_start in the same cycle with F_FULL → swap accepted, layer_active stays 1. load_start in the same cycle is ignored.
- rstn low mid-load (after 2 of 8 beats) → all outputs 0, F_IDLE, act_bank=0. A following load_len=8 starts again at wr_ptr 0.
